bist_arbiter: RTL and testbench
===============================

# bist_arbiter

Round-robin arbiter and sequencer that shares the single BIST `controller` among up to `N_REQ` requesters. It grants the controller to one requester at a time and issues the one-cycle `start` pulse. It then waits for `bist_end` and records a per-requester pass/fail result, aborting the session through the controller's `reset` on watchdog timeout or requester withdrawal. It sits between the requesting blocks and the `controller` instance.

## Interface
Parameters:
- `N_REQ`, default 4, number of requesters (2..16).
- `TIMEOUT`, default 255, maximum WAIT_END cycles before abort (≥1); counter width `$clog2(TIMEOUT+1)`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req`  in  N_REQ  level request per requester; held until its `done`.
- `grant`  out  N_REQ  one-hot owner of the controller; all-zero when idle.
- `busy`  out  1  high whenever state ≠ IDLE.
- `bist_start`  out  1  to controller `start`; one-cycle pulse.
- `bist_reset`  out  1  to controller `reset`; one-cycle abort pulse.
- `bist_end`  in  1  from controller `bist_end`.
- `bist_pass`  in  1  signature-compare result, valid with `bist_end`.
- `done`  out  N_REQ  one-cycle completion pulse to the owner.
- `result_pass`  out  N_REQ  sticky last result per requester.
- `timeout_err`  out  1  one-cycle pulse when a session is aborted by the watchdog.

## Operation
- All outputs are registered. On reset, all outputs are 0, state is IDLE, timer is 0, and the last-served pointer is N_REQ-1, so req[0] has first priority.
- IDLE: if any `req` bit is set, pick the first set bit searching upward from pointer+1 (wrapping). Load `grant` one-hot, update the pointer to the winner, and go to START.
- START, 1 cycle: `bist_start`=1, `grant` held. `bist_end` is ignored. Go to WAIT_END with the timer cleared.
- WAIT_END: the timer increments each cycle. Exits are evaluated in this priority order:
  - `bist_end`=1: latch `result_pass[idx]`=`bist_pass`, go to RELEASE.
  - `req[idx]`=0 (withdrawal): go to ABORT.
  - timer==TIMEOUT: set the timeout flag, go to ABORT.
- ABORT, 1 cycle: `bist_reset`=1, `result_pass[idx]`=0, go to RELEASE.
- RELEASE, 1 cycle: `done[idx]`=1. `timeout_err`=1 if the timeout flag is set; the flag clears. Go to IDLE. `grant` clears on entry to IDLE.
- Other `req` bits changing during a session have no effect until IDLE.
- A requester still holding `req` after `done` is re-arbitrated normally. It is served again only after all other pending requesters (round-robin).
- Only the owner's `result_pass` bit changes per session; other bits hold.

## Timing
- Request sampled in IDLE at edge k: `grant` and `bist_start` are high from k+1. `bist_start` drops at k+2.
- `bist_end` sampled at edge m: `done` and the updated `result_pass` are visible from m+1 for exactly one cycle. `grant`=0 from m+2. The earliest next `bist_start` is at m+3.
- Watchdog: WAIT_END lasts at most TIMEOUT+1 cycles.
  - `bist_reset` is high in the cycle after the timer reaches TIMEOUT.
  - `done` and `timeout_err` are high in the following cycle.
- Simultaneous events:
  - `bist_end` beats withdrawal and timeout in the same cycle; the result is latched normally and no `timeout_err` is raised.
  - Withdrawal and timeout in the same cycle: treated as a withdrawal, no `timeout_err`.
- Asynchronous `reset_n` mid-session returns the block to reset values immediately, including clearing `result_pass`. No `bist_reset` pulse is emitted; the system reset is expected to reset the controller too.
- `busy` is high in START, WAIT_END, ABORT and RELEASE.

## Test plan
All scenarios use N_REQ=4, TIMEOUT=20, 10 ns clock.
- Single request: req=0001 held; `bist_end`=1 with `bist_pass`=1 after 12 cycles.
  - Expect `bist_start` for 1 cycle after grant=0001, then `done`=0001 for 1 cycle, then `result_pass`=0001, then grant=0000.
- Round-robin: req=1111 held throughout.
  - Expect grants in order 0001, 0010, 0100, 1000, 0001.
  - Expect exactly 2 idle cycles between each `bist_end` and the next `bist_start`.
- Timeout: req=0100, `bist_end` never asserted.
  - Expect `bist_reset` pulse 21 cycles after `bist_start` falls.
  - Then `done`=0100 with `timeout_err`=1, and `result_pass[2]`=0.
- Withdrawal and collision:
  - Drop req[1] mid-session: expect ABORT, `bist_reset` pulse, `done`=0010, no `timeout_err`.
  - Repeat with the drop in the same cycle as `bist_end`: expect normal completion with the result latched.
- `bist_end` in START is ignored. Fail path: `bist_pass`=0 at end gives `result_pass[idx]`=0.
- Reset mid-session: assert `reset_n`=0 during WAIT_END.
  - Expect all outputs 0 asynchronously.
  - After release with req=1010, expect grant 0010 first.

Source files
------------

// File: rtl/bist_arbiter.sv
// Round-robin arbiter and session sequencer sharing one BIST controller among
// N_REQ requesters, with watchdog abort and a sticky per-requester result.
module bist_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             bist_start,
  output logic             bist_reset,
  input  logic             bist_end,
  input  logic             bist_pass,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] result_pass,
  output logic             timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_END,
    S_ABORT,
    S_RELEASE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;      // last-served requester, and owner during a session
  logic [TMR_W-1:0]   timer;
  logic               to_flag;
  logic               found;
  logic [IDX_W-1:0]   win_idx;
  int                 cand;

  // Search upward from ptr+1 with wrap-around; the owner itself is checked last.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    found   = 1'b0;
    win_idx = ptr;
    cand    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= IDX_W'(N_REQ - 1);
      timer       <= '0;
      to_flag     <= 1'b0;
      grant       <= '0;
      busy        <= 1'b0;
      bist_start  <= 1'b0;
      bist_reset  <= 1'b0;
      done        <= '0;
      result_pass <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      bist_start  <= 1'b0;
      bist_reset  <= 1'b0;
      done        <= '0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant      <= N_REQ'(1) << win_idx;
            ptr        <= win_idx;
            bist_start <= 1'b1;
            busy       <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT_END;
        end
        S_WAIT_END: begin
          if (bist_end) begin
            result_pass[ptr] <= bist_pass;
            done             <= grant;
            state            <= S_RELEASE;
          end else if (!req[ptr]) begin
            result_pass[ptr] <= 1'b0;
            bist_reset       <= 1'b1;
            state            <= S_ABORT;
          end else if (timer == TMR_W'(TIMEOUT)) begin
            to_flag          <= 1'b1;
            result_pass[ptr] <= 1'b0;
            bist_reset       <= 1'b1;
            state            <= S_ABORT;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_ABORT: begin
          done        <= grant;
          timeout_err <= to_flag;
          to_flag     <= 1'b0;
          state       <= S_RELEASE;
        end
        S_RELEASE: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_arbiter.sv
// Directed self-checking bench for bist_arbiter (N_REQ=4, TIMEOUT=20).
module tb_bist_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       busy;
  logic       bist_start;
  logic       bist_reset;
  logic       bist_end;
  logic       bist_pass;
  logic [3:0] done;
  logic [3:0] result_pass;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  bist_arbiter #(.N_REQ(4), .TIMEOUT(20)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .grant       (grant),
    .busy        (busy),
    .bist_start  (bist_start),
    .bist_reset  (bist_reset),
    .bist_end    (bist_end),
    .bist_pass   (bist_pass),
    .done        (done),
    .result_pass (result_pass),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are read 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".grant"},  grant, 4'b0000);
    check({tag, ".busy"},   {3'b0, busy}, 4'b0000);
    check({tag, ".start"},  {3'b0, bist_start}, 4'b0000);
    check({tag, ".breset"}, {3'b0, bist_reset}, 4'b0000);
    check({tag, ".done"},   done, 4'b0000);
    check({tag, ".rp"},     result_pass, 4'b0000);
    check({tag, ".tmo"},    {3'b0, timeout_err}, 4'b0000);
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    #2;
    check_all_zero("reset");
    #2 reset_n = 1'b1;
  endtask

  // One complete session ending in bist_end; starts with the DUT in IDLE and req applied.
  task automatic run_session(input string tag, input logic [3:0] exp_grant, input int gap,
                             input logic pass, input logic [3:0] exp_rp, input logic [3:0] req_after);
    tick();
    check({tag, ".grant"}, grant, exp_grant);
    check({tag, ".start"}, {3'b0, bist_start}, 4'b0001);
    check({tag, ".busy"},  {3'b0, busy}, 4'b0001);
    tick();
    check({tag, ".start_fall"}, {3'b0, bist_start}, 4'b0000);
    repeat (gap) tick();
    bist_end  = 1'b1;
    bist_pass = pass;
    tick();
    check({tag, ".done"}, done, exp_grant);
    check({tag, ".rp"},   result_pass, exp_rp);
    check({tag, ".tmo"},  {3'b0, timeout_err}, 4'b0000);
    check({tag, ".idle1_start"}, {3'b0, bist_start}, 4'b0000);
    bist_end = 1'b0;
    req      = req_after;
    tick();
    check({tag, ".done_clr"},  done, 4'b0000);
    check({tag, ".grant_clr"}, grant, 4'b0000);
    check({tag, ".busy_clr"},  {3'b0, busy}, 4'b0000);
    check({tag, ".idle2_start"}, {3'b0, bist_start}, 4'b0000);
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = 4'b0000;
    bist_end  = 1'b0;
    bist_pass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    #2 reset_n = 1'b1;

    // Single requester, pass
    req = 4'b0001;
    run_session("single", 4'b0001, 11, 1'b1, 4'b0001, 4'b0000);

    // Fresh reset so round-robin starts from requester 0; sticky result must clear
    do_reset();
    req = 4'b1111;
    run_session("rr0", 4'b0001, 3, 1'b1, 4'b0001, 4'b1111);
    run_session("rr1", 4'b0010, 0, 1'b1, 4'b0011, 4'b1111);
    run_session("rr2", 4'b0100, 5, 1'b1, 4'b0111, 4'b1111);
    run_session("rr3", 4'b1000, 1, 1'b1, 4'b1111, 4'b1111);
    run_session("rr4", 4'b0001, 2, 1'b1, 4'b1111, 4'b0000);

    // Watchdog timeout on requester 2
    req = 4'b0100;
    tick();
    check("tmo.grant", grant, 4'b0100);
    tick();
    check("tmo.start_fall", {3'b0, bist_start}, 4'b0000);
    repeat (20) tick();
    check("tmo.breset_early", {3'b0, bist_reset}, 4'b0000);
    check("tmo.busy", {3'b0, busy}, 4'b0001);
    tick();
    check("tmo.breset", {3'b0, bist_reset}, 4'b0001);
    check("tmo.done_early", done, 4'b0000);
    check("tmo.rp", result_pass, 4'b1011);
    tick();
    check("tmo.breset_fall", {3'b0, bist_reset}, 4'b0000);
    check("tmo.done", done, 4'b0100);
    check("tmo.err", {3'b0, timeout_err}, 4'b0001);
    req = 4'b0000;
    tick();
    check("tmo.err_clr", {3'b0, timeout_err}, 4'b0000);
    check("tmo.grant_clr", grant, 4'b0000);

    // Withdrawal of requester 1 mid-session
    req = 4'b0010;
    tick();
    check("wd.grant", grant, 4'b0010);
    tick();
    repeat (5) tick();
    req = 4'b0000;
    tick();
    check("wd.breset", {3'b0, bist_reset}, 4'b0001);
    check("wd.rp", result_pass, 4'b1001);
    tick();
    check("wd.done", done, 4'b0010);
    check("wd.err", {3'b0, timeout_err}, 4'b0000);
    tick();
    check("wd.grant_clr", grant, 4'b0000);

    // Withdrawal in the same cycle as bist_end: normal completion
    req = 4'b0010;
    tick();
    check("col.grant", grant, 4'b0010);
    tick();
    repeat (3) tick();
    req       = 4'b0000;
    bist_end  = 1'b1;
    bist_pass = 1'b1;
    tick();
    check("col.done", done, 4'b0010);
    check("col.breset", {3'b0, bist_reset}, 4'b0000);
    check("col.rp", result_pass, 4'b1011);
    check("col.err", {3'b0, timeout_err}, 4'b0000);
    bist_end = 1'b0;
    tick();
    check("col.grant_clr", grant, 4'b0000);

    // Withdrawal in the same cycle as the watchdog fires: no timeout_err
    req = 4'b1000;
    tick();
    check("wdt.grant", grant, 4'b1000);
    tick();
    repeat (20) tick();
    req = 4'b0000;
    tick();
    check("wdt.breset", {3'b0, bist_reset}, 4'b0001);
    tick();
    check("wdt.done", done, 4'b1000);
    check("wdt.err", {3'b0, timeout_err}, 4'b0000);
    check("wdt.rp", result_pass, 4'b0011);
    tick();

    // bist_end during START is ignored; then a failing signature
    req = 4'b0001;
    tick();
    check("ign.grant", grant, 4'b0001);
    bist_end  = 1'b1;
    bist_pass = 1'b1;
    tick();
    check("ign.done", done, 4'b0000);
    check("ign.busy", {3'b0, busy}, 4'b0001);
    check("ign.rp", result_pass, 4'b0011);
    bist_end = 1'b0;
    repeat (2) tick();
    bist_end  = 1'b1;
    bist_pass = 1'b0;
    tick();
    check("fail.done", done, 4'b0001);
    check("fail.rp", result_pass, 4'b0010);
    bist_end = 1'b0;
    req      = 4'b0000;
    tick();

    // Asynchronous reset during WAIT_END, then arbitration restarts from requester 0
    req = 4'b0010;
    tick();
    check("ar.grant", grant, 4'b0010);
    tick();
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async");
    req = 4'b1010;
    #2 reset_n = 1'b1;
    tick();
    check("ar.regrant", grant, 4'b0010);
    check("ar.start", {3'b0, bist_start}, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
